// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned FU_DATA_W    = 32;
    localparam int unsigned FU_MEM_WORDS = 64;
    localparam int unsigned PC_STEP      = 4;

    localparam logic [31:0] FU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FU_HALT_INST = 32'hFC00_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from downstream, program-memory port and IF/ID outputs.
interface fetch_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [DATA_W-1:0] redirect_pc_i;
    logic [DATA_W-1:0] inst_i;
    logic [DATA_W-1:0] pc_o;
    logic              if_id_valid_o;
    logic [DATA_W-1:0] if_id_inst_o;
    logic [DATA_W-1:0] if_id_pc_o;
    logic [DATA_W-1:0] if_id_pc4_o;
    logic              halted_o;
    logic              misalign_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, inst_i,
        input  pc_o, if_id_valid_o, if_id_inst_o, if_id_pc_o, if_id_pc4_o,
               halted_o, misalign_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, inst_i,
        output pc_o, if_id_valid_o, if_id_inst_o, if_id_pc_o, if_id_pc4_o,
               halted_o, misalign_o
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush wins over load, otherwise holds.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DATA_W = FU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] pc4_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] pc4_o
);

    logic              valid_q;
    logic [DATA_W-1:0] inst_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= DATA_W'(NOP);
            pc_q    <= '0;
            pc4_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= DATA_W'(NOP);
            pc_q    <= '0;
            pc4_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences BOOT/RUN/HALTED and feeds IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       DATA_W    = FU_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(FU_RESET_PC),
    parameter int unsigned       MEM_WORDS = FU_MEM_WORDS,
    parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(FU_HALT_INST)
) (
    input logic         clk,
    input logic         rst_n,
    fetch_unit_if.slave bus
);

    localparam int unsigned       ADDR_W  = $clog2(MEM_WORDS * PC_STEP);
    localparam logic [DATA_W-1:0] PC_MASK = DATA_W'((64'(1) << ADDR_W) - 64'(1));

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic              misalign_q, misalign_d;
    logic              ifid_load;
    logic              ifid_flush;

    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] redir_pc;
    logic              redir_mis;
    logic              is_halt;

    // Address arithmetic wraps at the memory size with upper bits forced to zero
    assign pc_inc    = (pc_q + DATA_W'(PC_STEP)) & PC_MASK;
    assign redir_pc  = {bus.redirect_pc_i[DATA_W-1:2], 2'b00} & PC_MASK;
    assign redir_mis = |bus.redirect_pc_i[1:0];
    assign is_halt   = (bus.inst_i == HALT_INST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.redirect_i && !bus.stall_i && is_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (bus.redirect_i) begin
                    state_d = ST_RUN;
                end
            end
            default:   state_d = ST_BOOT;
        endcase
    end

    // Redirect outranks stall and halt detection in both RUN and HALTED
    always_comb begin
        pc_d       = pc_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            ST_BOOT: ;
            ST_RUN: begin
                if (bus.redirect_i) begin
                    pc_d       = redir_pc;
                    ifid_flush = 1'b1;
                    misalign_d = misalign_q | redir_mis;
                end else if (!bus.stall_i) begin
                    ifid_load = 1'b1;
                    if (is_halt) begin
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.redirect_i) begin
                    pc_d       = redir_pc;
                    ifid_flush = 1'b1;
                    misalign_d = misalign_q | redir_mis;
                    halted_d   = 1'b0;
                end else if (!bus.stall_i) begin
                    ifid_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_unit_if_id_reg #(
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .inst_i  (bus.inst_i),
        .pc_i    (pc_q),
        .pc4_i   (pc_inc),
        .valid_o (bus.if_id_valid_o),
        .inst_o  (bus.if_id_inst_o),
        .pc_o    (bus.if_id_pc_o),
        .pc4_o   (bus.if_id_pc4_o)
    );

    assign bus.pc_o       = pc_q;
    assign bus.halted_o   = halted_q;
    assign bus.misalign_o = misalign_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the program memory.
- Owns the program counter and drives it to the memory as a byte address.
- Registers the word the memory returns (combinational read) into the IF/ID pipeline register consumed by the decoder.
- Handles sequential fetch, stall, branch/jump redirect with flush, and a halt instruction.

Parameters:
- DATA_W, 32, width of PC and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 64, program memory depth in words; PC wraps modulo MEM_WORDS*4.
- HALT_INST, 32'hFC00_0000, encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold PC and IF/ID (hazard from downstream).
- redirect_i  in  1  taken branch/jump; load redirect_pc_i.
- redirect_pc_i  in  DATA_W  branch/jump target byte address.
- inst_i  in  DATA_W  word returned by program memory for pc_o, same cycle.
- pc_o  out  DATA_W  current fetch address to program memory.
- if_id_valid_o  out  1  IF/ID contents are a real instruction.
- if_id_inst_o  out  DATA_W  registered instruction (0 = NOP when invalid).
- if_id_pc_o  out  DATA_W  address of if_id_inst_o.
- if_id_pc4_o  out  DATA_W  if_id_pc_o + 4 (wrapped), for link/branch base.
- halted_o  out  1  fetch stopped by HALT_INST.
- misalign_o  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset:
  - Asserting rst_n low clears all state immediately, regardless of clk: pc_o=RESET_PC, if_id_valid_o=0, if_id_inst_o=0, if_id_pc_o=0, if_id_pc4_o=0, halted_o=0, misalign_o=0, state=BOOT.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: one cycle only. IF/ID stays invalid and PC holds. Next state is RUN unconditionally; stall_i and redirect_i are ignored in BOOT.
- RUN, evaluated each rising edge in this priority order:
  - 1. redirect_i=1: pc <= {redirect_pc_i[31:2],2'b00} mod MEM_WORDS*4; IF/ID flushed (valid=0, inst=0, pc/pc4 = 0); misalign_o set if redirect_pc_i[1:0]!=0. Redirect overrides stall_i and halt detection.
  - 2. stall_i=1: pc and all IF/ID fields hold.
  - 3. inst_i==HALT_INST: IF/ID captures it (valid=1, inst, pc, pc4); pc holds; next state is HALTED.
  - 4. Otherwise:
    - IF/ID captures valid=1, inst=inst_i, pc=pc_o, pc4=pc_o+4.
    - pc <= (pc_o+4) mod MEM_WORDS*4. Wrap example for the default depth: 32'hFC -> 32'h00.
- HALTED:
  - halted_o=1 and pc holds.
  - With stall_i=1, IF/ID holds; otherwise the next edge clears IF/ID valid (no refetch).
  - redirect_i=1 behaves as in RUN (load target, flush, set misalign_o if needed), clears halted_o, and moves to RUN.
- Latency:
  - One edge from pc_o to the IF/ID capture.
  - One edge from redirect_i to the new pc_o; the first target instruction appears in IF/ID one further edge later.
- Arithmetic:
  - PC adders are DATA_W wide.
  - Wrap is applied by masking to log2(MEM_WORDS*4) bits; upper bits are forced 0.
- misalign_o is cleared only by reset.
- pc_o is always word-aligned.

Decomposition:
- Shared package holds:
  - FSM state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
  - HALT_INST and NOP (32'h0) constants.
  - PC_STEP=4.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush controls and async active-low clear. The PC/next-PC logic and FSM stay in fetch_unit.

Test Plan:
- Reset release, memory words 0x11,0x22,0x33 at addresses 0,4,8, no stall:
  - One BOOT cycle with valid=0.
  - Then IF/ID shows (pc=0, inst=0x11), (4, 0x22), (8, 0x33) on consecutive cycles; pc4 = 4, 8, 0xC.
- Stall held 3 cycles while IF/ID holds (pc=4, inst=0x22): pc_o stays 8 and IF/ID is unchanged all 3 cycles; after release, (8, 0x33) is captured.
- redirect_i=1 with target 0x20, asserted with stall_i=1 and pc_o=0x0C:
  - Next cycle pc_o=0x20 and valid=0.
  - Following cycle IF/ID holds (pc=0x20, inst = mem[8]).
- Sequential run to 0xFC: next pc_o=0x00 and if_id_pc4_o=0x00 for the 0xFC instruction.
- HALT_INST at 0x10:
  - IF/ID captures it with valid=1; halted_o=1 next edge; pc_o stays 0x10.
  - Next cycle valid=0.
  - Redirect to 0x00 clears halted_o and resumes fetch at 0.
- Redirect target 0x22: pc_o=0x20 and misalign_o=1 sticky. Asserting rst_n=0 mid-cycle clears everything immediately, without a clock edge.
